// File: rtl/mdio_arbiter_pkg.sv
// Shared types and constants for the MDIO requester arbiter.
// Holds the FSM state encoding, MDIO field widths, the latched-op and
// response payload structs, and the round-robin pointer advance helper.
package mdio_arbiter_pkg;

  localparam int unsigned MDIO_ADDR_W = 5;
  localparam int unsigned MDIO_DATA_W = 16;
  localparam int unsigned GRANT_W     = 3;
  localparam int unsigned CNT_W       = 16;

  localparam logic MDIO_OP_WR = 1'b0;
  localparam logic MDIO_OP_RD = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ISSUE = 3'd1,
    ST_WAIT  = 3'd2,
    ST_DRAIN = 3'd3,
    ST_DONE  = 3'd4
  } arb_state_e;

  // Operation latched from the granted requester and presented to mdio_dri.
  typedef struct packed {
    logic                   rh_wl;
    logic [MDIO_ADDR_W-1:0] addr;
    logic [MDIO_DATA_W-1:0] wr_data;
  } mdio_op_t;

  // Result returned to the served requester.
  typedef struct packed {
    logic                   err;
    logic                   rd_ack;
    logic [MDIO_DATA_W-1:0] rd_data;
  } mdio_rsp_t;

  localparam mdio_rsp_t RSP_RESET   = '{err: 1'b0, rd_ack: 1'b1, rd_data: 16'h0000};
  localparam mdio_rsp_t RSP_TIMEOUT = '{err: 1'b1, rd_ack: 1'b1, rd_data: 16'hFFFF};

  // Next round-robin start index: one past the last grant, wrapping at n.
  function automatic logic [GRANT_W-1:0] rr_next(input logic [GRANT_W-1:0] id,
                                                 input int unsigned        n);
    return (32'(id) == n - 1) ? '0 : id + GRANT_W'(1);
  endfunction

endpackage

// File: rtl/mdio_arbiter_if.sv
// Bundle of the requester-side and driver-side signals of mdio_arbiter.
// slave  : arbiter view (takes requests, drives the mdio_dri op interface)
// master : environment view (requesters plus mdio_dri)
// Per-requester fields are packed: requester i at addr[5i+:5], wr_data[16i+:16].
interface mdio_arbiter_if
  import mdio_arbiter_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4
);

  logic [NUM_REQ-1:0]             req_valid;
  logic [NUM_REQ-1:0]             req_rh_wl;
  logic [MDIO_ADDR_W*NUM_REQ-1:0] req_addr;
  logic [MDIO_DATA_W*NUM_REQ-1:0] req_wr_data;
  logic [NUM_REQ-1:0]             req_done;
  logic                           req_err;
  logic [MDIO_DATA_W-1:0]         req_rd_data;
  logic                           req_rd_ack;

  logic                           op_exec;
  logic                           op_rh_wl;
  logic [MDIO_ADDR_W-1:0]         op_addr;
  logic [MDIO_DATA_W-1:0]         op_wr_data;
  logic                           op_done;
  logic [MDIO_DATA_W-1:0]         op_rd_data;
  logic                           op_rd_ack;

  modport slave (
    input  req_valid, req_rh_wl, req_addr, req_wr_data,
    input  op_done, op_rd_data, op_rd_ack,
    output req_done, req_err, req_rd_data, req_rd_ack,
    output op_exec, op_rh_wl, op_addr, op_wr_data
  );

  modport master (
    output req_valid, req_rh_wl, req_addr, req_wr_data,
    output op_done, op_rd_data, op_rd_ack,
    input  req_done, req_err, req_rd_data, req_rd_ack,
    input  op_exec, op_rh_wl, op_addr, op_wr_data
  );

endinterface

// File: rtl/mdio_rr_pick.sv
// Combinational round-robin picker.
// req_valid : per-requester request level
// ptr       : index that gets first priority
// found     : at least one request is valid
// idx       : first valid index at or after ptr, wrapping modulo NUM_REQ
module mdio_rr_pick
  import mdio_arbiter_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0] req_valid,
  input  logic [GRANT_W-1:0] ptr,
  output logic               found,
  output logic [GRANT_W-1:0] idx
);

  logic [NUM_REQ-1:0] rot;
  int unsigned        sum;

  // Rotate so ptr lands at bit 0, then take the lowest set bit.
  always_comb begin
    rot   = NUM_REQ'({req_valid, req_valid} >> ptr);
    found = 1'b0;
    idx   = '0;
    sum   = 0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      if (rot[k] && !found) begin
        found = 1'b1;
        sum   = 32'(ptr) + k;
        if (sum >= NUM_REQ) sum = sum - NUM_REQ;
        idx   = GRANT_W'(sum);
      end
    end
  end

endmodule

// File: rtl/mdio_arbiter.sv
// Shares one mdio_dri op interface between NUM_REQ requesters.
// Round-robin grant, one outstanding MDIO transaction, and a watchdog so a
// silent PHY cannot lock out the other requesters.
// Ports:
//   clk, rst_n : driver clock, async active-low reset
//   bus        : requester + mdio_dri signals (mdio_arbiter_if.slave)
//   busy       : 1 whenever the FSM is not idle
//   grant_id   : index of the current/last granted requester
module mdio_arbiter
  import mdio_arbiter_pkg::*;
#(
  parameter int unsigned       NUM_REQ     = 4,
  parameter logic [CNT_W-1:0]  TIMEOUT_CYC = 16'd2048
) (
  input  logic               clk,
  input  logic               rst_n,
  mdio_arbiter_if.slave      bus,
  output logic               busy,
  output logic [GRANT_W-1:0] grant_id
);

  arb_state_e         state_q, state_d;
  logic [GRANT_W-1:0] ptr_q, ptr_d;
  logic [GRANT_W-1:0] grant_q, grant_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  mdio_op_t           op_q, op_d;
  mdio_rsp_t          rsp_q, rsp_d;
  logic               exec_q, exec_d;
  logic [NUM_REQ-1:0] done_q, done_d;
  logic               busy_q, busy_d;

  logic               pick_found;
  logic [GRANT_W-1:0] pick_idx;
  mdio_op_t           sel_op;
  logic [NUM_REQ-1:0] grant_onehot;
  logic               timeout_hit;

  mdio_rr_pick #(
    .NUM_REQ (NUM_REQ)
  ) u_pick (
    .req_valid (bus.req_valid),
    .ptr       (ptr_q),
    .found     (pick_found),
    .idx       (pick_idx)
  );

  // Fields of the requester the picker chose.
  always_comb begin
    sel_op = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (pick_idx == GRANT_W'(i)) begin
        sel_op.rh_wl   = bus.req_rh_wl[i];
        sel_op.addr    = bus.req_addr[i*MDIO_ADDR_W +: MDIO_ADDR_W];
        sel_op.wr_data = bus.req_wr_data[i*MDIO_DATA_W +: MDIO_DATA_W];
      end
    end
  end

  // Done pulse lands on the granted requester only.
  always_comb begin
    grant_onehot = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      grant_onehot[i] = (grant_q == GRANT_W'(i));
    end
  end

  assign timeout_hit = (cnt_q == TIMEOUT_CYC - CNT_W'(1));

  // Next-state and next-output logic.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    grant_d = grant_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    rsp_d   = rsp_q;
    exec_d  = 1'b0;
    done_d  = '0;

    case (state_q)
      ST_IDLE: begin
        if (pick_found) begin
          op_d    = sel_op;
          grant_d = pick_idx;
          exec_d  = 1'b1;
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        cnt_d   = '0;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        cnt_d = cnt_q + CNT_W'(1);
        // A done in the same cycle as expiry still counts as success.
        if (bus.op_done) begin
          rsp_d   = '{err: 1'b0, rd_ack: bus.op_rd_ack, rd_data: bus.op_rd_data};
          done_d  = grant_onehot;
          state_d = ST_DONE;
        end else if (timeout_hit) begin
          rsp_d   = RSP_TIMEOUT;
          cnt_d   = '0;
          state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        // Hold off new issues until the driver is idle; late data is dropped.
        cnt_d = cnt_q + CNT_W'(1);
        if (bus.op_done || timeout_hit) begin
          done_d  = grant_onehot;
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        ptr_d   = rr_next(grant_q, NUM_REQ);
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      ptr_q   <= '0;
      grant_q <= '0;
      cnt_q   <= '0;
      op_q    <= '0;
      rsp_q   <= RSP_RESET;
      exec_q  <= 1'b0;
      done_q  <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      grant_q <= grant_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      rsp_q   <= rsp_d;
      exec_q  <= exec_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
    end
  end

  assign bus.op_exec     = exec_q;
  assign bus.op_rh_wl    = op_q.rh_wl;
  assign bus.op_addr     = op_q.addr;
  assign bus.op_wr_data  = op_q.wr_data;
  assign bus.req_done    = done_q;
  assign bus.req_err     = rsp_q.err;
  assign bus.req_rd_data = rsp_q.rd_data;
  assign bus.req_rd_ack  = rsp_q.rd_ack;
  assign busy            = busy_q;
  assign grant_id        = grant_q;

endmodule

// File: tb/tb_mdio_arbiter.sv
// Directed bench for mdio_arbiter with a behavioural mdio_dri model whose
// op_done latency is set per scenario (never-answering for the watchdog case).
module tb_mdio_arbiter;
  import mdio_arbiter_pkg::*;

  localparam int unsigned      NR = 4;
  localparam logic [CNT_W-1:0] TO = 16'd16;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               busy;
  logic [GRANT_W-1:0] grant_id;

  always #5 clk = ~clk;

  mdio_arbiter_if #(.NUM_REQ(NR)) bus ();

  mdio_arbiter #(
    .NUM_REQ     (NR),
    .TIMEOUT_CYC (TO)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (bus),
    .busy     (busy),
    .grant_id (grant_id)
  );

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // mdio_dri model: op_done model_lat cycles after op_exec; model_lat<=0 never answers.
  int               model_lat = 12;
  logic [15:0]      model_data = 16'h0000;
  logic             model_ack = 1'b0;
  bit               pend = 1'b0;
  int               pcnt = 0;

  initial begin
    bus.op_done    = 1'b0;
    bus.op_rd_data = 16'h0000;
    bus.op_rd_ack  = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      bus.op_done = 1'b0;
      if (!rst_n) begin
        pend = 1'b0;
      end else if (pend) begin
        pcnt--;
        if (pcnt == 0) begin
          bus.op_done    = 1'b1;
          bus.op_rd_data = model_data;
          bus.op_rd_ack  = model_ack;
          pend           = 1'b0;
        end
      end
      if (rst_n && bus.op_exec && model_lat > 0) begin
        pend = 1'b1;
        pcnt = model_lat;
      end
    end
  end

  // Passive monitor, sampled mid-cycle.
  int          exec_cnt = 0, exec_cyc = 0, done_cnt = 0, done_cyc = 0, overlap_cnt = 0;
  logic        exec_rh_wl = 1'b0;
  logic [15:0] exec_wr_data = 16'h0;
  logic [3:0]  done_vec = 4'h0;
  logic [15:0] res_data = 16'h0;
  logic        res_ack = 1'b0, res_err = 1'b0;
  bit          outstanding = 1'b0;
  int          grant_log[$];
  int          addr_log[$];

  always @(negedge clk) begin
    if (!rst_n) begin
      outstanding = 1'b0;
    end else begin
      if (bus.op_exec) begin
        if (outstanding) overlap_cnt++;
        outstanding  = 1'b1;
        exec_cnt++;
        exec_cyc     = cyc;
        exec_rh_wl   = bus.op_rh_wl;
        exec_wr_data = bus.op_wr_data;
        addr_log.push_back(int'(bus.op_addr));
      end
      if (bus.req_done != '0) begin
        outstanding = 1'b0;
        done_cnt++;
        done_cyc = cyc;
        done_vec = bus.req_done;
        res_data = bus.req_rd_data;
        res_ack  = bus.req_rd_ack;
        res_err  = bus.req_err;
        grant_log.push_back(int'(grant_id));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  // Advance until n req_done pulses were seen; requesters drop req_valid the edge after.
  task automatic run_dones(input int n, input int max_cyc);
    int         start;
    int         k;
    logic [3:0] drop;
    start = done_cnt;
    k     = 0;
    drop  = '0;
    while (k < max_cyc) begin
      @(posedge clk);
      #1;
      k++;
      if (drop != '0) begin
        bus.req_valid = bus.req_valid & ~drop;
        drop = '0;
        if (done_cnt - start >= n) break;
      end
      drop = bus.req_done;
    end
    checks++;
    if (done_cnt - start != n) begin
      errors++;
      $display("FAIL run_dones: saw %0d req_done pulses, required %0d", done_cnt - start, n);
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b need 0", busy); end
    checks++; if (bus.op_exec !== 1'b0) begin errors++; $display("FAIL reset_exec: got %b need 0", bus.op_exec); end
    checks++; if (bus.req_done !== 4'b0000) begin errors++; $display("FAIL reset_done: got %b need 0000", bus.req_done); end
    checks++; if (bus.req_rd_data !== 16'h0000) begin errors++; $display("FAIL reset_rd_data: got %h need 0000", bus.req_rd_data); end
    checks++; if (bus.req_rd_ack !== 1'b1) begin errors++; $display("FAIL reset_rd_ack: got %b need 1", bus.req_rd_ack); end
    checks++; if (bus.req_err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b need 0", bus.req_err); end
    checks++; if (grant_id !== 3'd0) begin errors++; $display("FAIL reset_grant: got %0d need 0", grant_id); end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_single_read;
    int e0;
    int set_cyc;
    e0         = exec_cnt;
    model_lat  = 12;
    model_data = 16'h796D;
    model_ack  = 1'b0;
    bus.req_rh_wl[0]  = MDIO_OP_RD;
    bus.req_addr[4:0] = 5'h01;
    bus.req_valid[0]  = 1'b1;
    set_cyc = cyc;
    run_dones(1, 60);
    checks++; if (exec_cnt - e0 != 1) begin errors++; $display("FAIL rd_exec_count: got %0d need 1", exec_cnt - e0); end
    checks++; if (exec_cyc != set_cyc + 1) begin errors++; $display("FAIL rd_exec_latency: got %0d need %0d", exec_cyc - set_cyc, 1); end
    checks++; if (addr_log[$] != 1 || exec_rh_wl !== 1'b1) begin errors++; $display("FAIL rd_op_fields: got addr %0d rh_wl %b need 1/1", addr_log[$], exec_rh_wl); end
    checks++; if (done_vec !== 4'b0001) begin errors++; $display("FAIL rd_done_vec: got %b need 0001", done_vec); end
    checks++; if (done_cyc != exec_cyc + 13) begin errors++; $display("FAIL rd_done_latency: got %0d need 13", done_cyc - exec_cyc); end
    checks++; if (res_data !== 16'h796D) begin errors++; $display("FAIL rd_data: got %h need 796d", res_data); end
    checks++; if (res_ack !== 1'b0 || res_err !== 1'b0) begin errors++; $display("FAIL rd_ack_err: got %b/%b need 0/0", res_ack, res_err); end
  endtask

  task automatic test_rr_wrap;
    int g0;
    model_lat  = 12;
    model_data = 16'h0042;
    model_ack  = 1'b0;
    bus.req_rh_wl[3]          = MDIO_OP_WR;
    bus.req_addr[19:15]       = 5'h03;
    bus.req_wr_data[63:48]    = 16'hA5A5;
    bus.req_valid[3]          = 1'b1;
    run_dones(1, 60);
    checks++; if (grant_log[$] != 3) begin errors++; $display("FAIL wr_grant: got %0d need 3", grant_log[$]); end
    checks++; if (exec_rh_wl !== 1'b0 || exec_wr_data !== 16'hA5A5) begin errors++; $display("FAIL wr_op_fields: got %b/%h need 0/a5a5", exec_rh_wl, exec_wr_data); end
    checks++; if (res_data !== 16'h0042) begin errors++; $display("FAIL wr_rd_data: got %h need 0042", res_data); end
    g0 = grant_log.size();
    bus.req_rh_wl[0]  = MDIO_OP_RD;
    bus.req_addr[4:0] = 5'h02;
    bus.req_valid[0]  = 1'b1;
    bus.req_valid[3]  = 1'b1;
    run_dones(2, 100);
    checks++;
    if (grant_log.size() < g0 + 2) begin
      errors++; $display("FAIL wrap_order: got %0d grants need 2", grant_log.size() - g0);
    end else if (grant_log[g0] != 0 || grant_log[g0+1] != 3) begin
      errors++; $display("FAIL wrap_order: got %0d,%0d need 0,3", grant_log[g0], grant_log[g0+1]);
    end
  endtask

  task automatic test_simultaneous;
    int g0, a0, e0, o0;
    model_lat = 12;
    for (int i = 0; i < 4; i++) begin
      bus.req_rh_wl[i]           = MDIO_OP_RD;
      bus.req_addr[i*5 +: 5]     = 5'(4 + i);
      bus.req_wr_data[i*16 +: 16] = 16'(16'h1000 + i);
    end
    g0 = grant_log.size();
    a0 = addr_log.size();
    e0 = exec_cnt;
    o0 = overlap_cnt;
    bus.req_valid = 4'b1111;
    run_dones(4, 200);
    checks++; if (exec_cnt - e0 != 4) begin errors++; $display("FAIL sim_exec_count: got %0d need 4", exec_cnt - e0); end
    checks++; if (overlap_cnt != o0) begin errors++; $display("FAIL sim_overlap: got %0d need 0", overlap_cnt - o0); end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (grant_log.size() <= g0 + i || addr_log.size() <= a0 + i) begin
        errors++; $display("FAIL sim_order%0d: entry missing", i);
      end else if (grant_log[g0+i] != i || addr_log[a0+i] != 4 + i) begin
        errors++; $display("FAIL sim_order%0d: got grant %0d addr %0d need %0d/%0d",
                           i, grant_log[g0+i], addr_log[a0+i], i, 4 + i);
      end
    end
  endtask

  task automatic test_timeout_silent;
    model_lat = -1;
    bus.req_rh_wl[1]   = MDIO_OP_RD;
    bus.req_addr[9:5]  = 5'h11;
    bus.req_valid[1]   = 1'b1;
    run_dones(1, 80);
    checks++; if (done_cyc != exec_cyc + 33) begin errors++; $display("FAIL to_latency: got %0d need 33", done_cyc - exec_cyc); end
    checks++; if (done_vec !== 4'b0010) begin errors++; $display("FAIL to_done_vec: got %b need 0010", done_vec); end
    checks++; if (res_err !== 1'b1 || res_data !== 16'hFFFF || res_ack !== 1'b1) begin
      errors++; $display("FAIL to_result: got err %b data %h ack %b need 1/ffff/1", res_err, res_data, res_ack);
    end
    model_lat = 12;
  endtask

  task automatic test_timeout_late;
    model_lat  = 20;
    model_data = 16'hBEEF;
    model_ack  = 1'b0;
    bus.req_rh_wl[2]    = MDIO_OP_RD;
    bus.req_addr[14:10] = 5'h12;
    bus.req_valid[2]    = 1'b1;
    run_dones(1, 80);
    checks++; if (done_cyc != exec_cyc + 21) begin errors++; $display("FAIL late_latency: got %0d need 21", done_cyc - exec_cyc); end
    checks++; if (res_err !== 1'b1 || res_data !== 16'hFFFF || res_ack !== 1'b1) begin
      errors++; $display("FAIL late_result: got err %b data %h ack %b need 1/ffff/1", res_err, res_data, res_ack);
    end
    model_lat  = 12;
    model_data = 16'h1357;
    bus.req_rh_wl[0]  = MDIO_OP_RD;
    bus.req_addr[4:0] = 5'h05;
    bus.req_valid[0]  = 1'b1;
    run_dones(1, 60);
    checks++; if (grant_log[$] != 0 || done_cyc != exec_cyc + 13) begin
      errors++; $display("FAIL late_next: got grant %0d latency %0d need 0/13", grant_log[$], done_cyc - exec_cyc);
    end
    checks++; if (res_err !== 1'b0 || res_data !== 16'h1357 || res_ack !== 1'b0) begin
      errors++; $display("FAIL late_next_result: got err %b data %h ack %b need 0/1357/0", res_err, res_data, res_ack);
    end
  endtask

  task automatic test_reset_mid_op;
    int e0, d0, k;
    model_lat  = 12;
    model_data = 16'h2468;
    model_ack  = 1'b0;
    bus.req_rh_wl[1]  = MDIO_OP_RD;
    bus.req_addr[9:5] = 5'h09;
    e0 = exec_cnt;
    bus.req_valid[1] = 1'b1;
    k = 0;
    while (exec_cnt == e0 && k < 10) begin
      @(posedge clk);
      #1;
      k++;
    end
    checks++; if (exec_cnt == e0) begin errors++; $display("FAIL rst_issue: no op_exec within 10 cycles"); end
    repeat (5) @(posedge clk);
    d0 = done_cnt;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++; if (busy !== 1'b0 || grant_id !== 3'd0) begin errors++; $display("FAIL rst_mid_state: got busy %b grant %0d need 0/0", busy, grant_id); end
    checks++; if (bus.op_exec !== 1'b0 || bus.op_addr !== 5'h00 || bus.op_rh_wl !== 1'b0) begin
      errors++; $display("FAIL rst_mid_op: got exec %b addr %h rh_wl %b need 0/00/0", bus.op_exec, bus.op_addr, bus.op_rh_wl);
    end
    checks++; if (bus.req_rd_data !== 16'h0000 || bus.req_rd_ack !== 1'b1 || bus.req_err !== 1'b0) begin
      errors++; $display("FAIL rst_mid_rsp: got %h/%b/%b need 0000/1/0", bus.req_rd_data, bus.req_rd_ack, bus.req_err);
    end
    repeat (3) @(negedge clk);
    checks++; if (done_cnt != d0) begin errors++; $display("FAIL rst_mid_no_done: got %0d pulses need 0", done_cnt - d0); end
    rst_n = 1'b1;
    run_dones(1, 60);
    checks++; if (done_vec !== 4'b0010 || grant_log[$] != 1) begin
      errors++; $display("FAIL rst_regrant: got vec %b grant %0d need 0010/1", done_vec, grant_log[$]);
    end
    checks++; if (res_data !== 16'h2468 || res_err !== 1'b0) begin
      errors++; $display("FAIL rst_regrant_data: got %h err %b need 2468/0", res_data, res_err);
    end
  endtask

  initial begin
    bus.req_valid   = '0;
    bus.req_rh_wl   = '0;
    bus.req_addr    = '0;
    bus.req_wr_data = '0;
    test_reset();
    test_single_read();
    test_rr_wrap();
    test_simultaneous();
    test_timeout_silent();
    test_timeout_late();
    test_reset_mid_op();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
